// File: rtl/seq_pattern_tx_if.sv
`default_nettype none
// ============================================================================
// seq_pattern_tx_if : request/stream bundle between a pattern source and
// seq_pattern_tx.                                            Rev 1.0
// ============================================================================
interface seq_pattern_tx_if #(
  parameter int PAT_W = 8
);
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic             ready;
  logic             bit_out;
  logic             bit_strobe;
  logic             in_frame;
  logic             frame_done;
  logic [7:0]       sent_count;

  modport master (
    output start,
    output pattern,
    input  ready,
    input  bit_out,
    input  bit_strobe,
    input  in_frame,
    input  frame_done,
    input  sent_count
  );

  modport slave (
    input  start,
    input  pattern,
    output ready,
    output bit_out,
    output bit_strobe,
    output in_frame,
    output frame_done,
    output sent_count
  );
endinterface
`default_nettype wire

// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// seq_pattern_tx : tick-paced serializer emitting a framed pattern MSB first,
// with 24-bit LFSR filler bits between frames.               Rev 1.0
// ============================================================================
module seq_pattern_tx #(
  parameter int          PAT_W     = 8,
  parameter int          DIV       = 4,
  parameter int          GAP_LEN   = 16,
  parameter logic [23:0] LFSR_SEED = 24'h5A5A5A
) (
  input  logic            clk_in,
  input  logic            reset,
  seq_pattern_tx_if.slave bus
);
  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = $clog2(PAT_W);
  localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LOAD = IDX_W'(PAT_W - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [23:0]      lfsr_q, lfsr_d;
  logic [PAT_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0] bitidx_q, bitidx_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             ready_q, ready_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_strobe_q, bit_strobe_d;
  logic             in_frame_q, in_frame_d;
  logic             frame_done_q, frame_done_d;
  logic [7:0]       sent_count_q, sent_count_d;

  logic             tick;
  logic [23:0]      lfsr_shifted;

  assign tick         = (cnt_q == CNT_LAST);
  assign lfsr_shifted = {lfsr_q[22:0], lfsr_q[23] ^ lfsr_q[22] ^ lfsr_q[21] ^ lfsr_q[16]};

  always_comb begin
    state_d      = state_q;
    cnt_d        = tick ? '0 : cnt_q + CNT_W'(1);
    lfsr_d       = lfsr_q;
    shreg_d      = shreg_q;
    bitidx_d     = bitidx_q;
    gap_cnt_d    = gap_cnt_q;
    bit_out_d    = bit_out_q;
    in_frame_d   = in_frame_q;
    sent_count_d = sent_count_q;
    bit_strobe_d = 1'b0;
    frame_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Accept wins over a coincident tick and restarts the bit period.
        if (bus.start && ready_q) begin
          bit_out_d    = bus.pattern[PAT_W-1];
          shreg_d      = bus.pattern << 1;
          bitidx_d     = IDX_LOAD;
          cnt_d        = '0;
          in_frame_d   = 1'b1;
          bit_strobe_d = 1'b1;
          state_d      = SEND;
        end else if (tick) begin
          bit_out_d = lfsr_q[23];
          lfsr_d    = lfsr_shifted;
        end
      end
      SEND: begin
        if (tick) begin
          if (bitidx_q != '0) begin
            bit_out_d    = shreg_q[PAT_W-1];
            shreg_d      = shreg_q << 1;
            bitidx_d     = bitidx_q - IDX_W'(1);
            bit_strobe_d = 1'b1;
          end else begin
            bit_out_d    = lfsr_q[23];
            lfsr_d       = lfsr_shifted;
            in_frame_d   = 1'b0;
            frame_done_d = 1'b1;
            sent_count_d = sent_count_q + 8'd1;
            gap_cnt_d    = GAP_LOAD;
            state_d      = GAP;
          end
        end
      end
      GAP: begin
        if (tick) begin
          bit_out_d = lfsr_q[23];
          lfsr_d    = lfsr_shifted;
          if (gap_cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lfsr_q       <= LFSR_SEED;
      shreg_q      <= '0;
      bitidx_q     <= '0;
      gap_cnt_q    <= '0;
      ready_q      <= 1'b1;
      bit_out_q    <= 1'b0;
      bit_strobe_q <= 1'b0;
      in_frame_q   <= 1'b0;
      frame_done_q <= 1'b0;
      sent_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lfsr_q       <= lfsr_d;
      shreg_q      <= shreg_d;
      bitidx_q     <= bitidx_d;
      gap_cnt_q    <= gap_cnt_d;
      ready_q      <= ready_d;
      bit_out_q    <= bit_out_d;
      bit_strobe_q <= bit_strobe_d;
      in_frame_q   <= in_frame_d;
      frame_done_q <= frame_done_d;
      sent_count_q <= sent_count_d;
    end
  end

  assign bus.ready      = ready_q;
  assign bus.bit_out    = bit_out_q;
  assign bus.bit_strobe = bit_strobe_q;
  assign bus.in_frame   = in_frame_q;
  assign bus.frame_done = frame_done_q;
  assign bus.sent_count = sent_count_q;
endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// tb_seq_pattern_tx : randomized scoreboard bench for seq_pattern_tx.
//                                                            Rev 1.0
// ============================================================================
module tb_seq_pattern_tx;
  localparam int          PAT_W     = 8;
  localparam int          DIV       = 4;
  localparam int          GAP_LEN   = 16;
  localparam logic [23:0] SEED      = 24'h5A5A5A;
  localparam int          FRAME_CYC = PAT_W * DIV;
  localparam int          BUSY_CYC  = (PAT_W + GAP_LEN) * DIV;

  logic clk_in = 1'b0;
  logic reset  = 1'b0;

  seq_pattern_tx_if #(.PAT_W(PAT_W)) bus ();

  seq_pattern_tx #(
    .PAT_W    (PAT_W),
    .DIV      (DIV),
    .GAP_LEN  (GAP_LEN),
    .LFSR_SEED(SEED)
  ) dut (
    .clk_in(clk_in),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int   edge_n;
    logic b;
  } bit_ev_t;

  typedef struct {
    int         edge_n;
    logic [7:0] cnt;
  } done_ev_t;

  bit_ev_t  q_bits[$];
  bit_ev_t  q_fill[$];
  done_ev_t q_done[$];

  int total = 0;
  int bad   = 0;

  // Reference model: absolute edge numbers of expected events.
  int          cyc          = 0;
  int          m_anchor     = 0;
  int          m_acc        = -100000;
  int          m_ready_edge = 0;
  int          m_count      = 0;
  logic [23:0] m_lfsr       = SEED;
  bit          m_fresh      = 1'b1;
  bit          m_live       = 1'b0;

  bit_ev_t  p_ev;
  done_ev_t p_dev;
  bit_ev_t  mon_ev;
  done_ev_t mon_dev;
  bit       exp_strobe, exp_done, exp_fill;
  logic     prev_bit = 1'b0;

  function automatic logic [23:0] lfsr_step(input logic [23:0] s);
    return {s[22:0], ^(s & 24'hE10000)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Predictor: on every edge decide accept / filler bit from spec timing.
  always @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      q_bits.delete();
      q_fill.delete();
      q_done.delete();
      m_lfsr       = SEED;
      m_count      = 0;
      m_acc        = -100000;
      m_ready_edge = cyc;
      m_fresh      = 1'b1;
    end else begin
      cyc++;
      if (m_fresh) begin
        m_anchor = cyc - 1;
        m_fresh  = 1'b0;
        m_live   = 1'b1;
      end
      if (bus.start && (cyc - 1 >= m_ready_edge)) begin
        m_acc        = cyc;
        m_anchor     = cyc;
        m_ready_edge = cyc + BUSY_CYC;
        for (int k = 0; k < PAT_W; k++) begin
          p_ev.edge_n = cyc + k * DIV;
          p_ev.b      = bus.pattern[PAT_W-1-k];
          q_bits.push_back(p_ev);
        end
        m_count      = (m_count + 1) % 256;
        p_dev.edge_n = cyc + FRAME_CYC;
        p_dev.cnt    = 8'(m_count);
        q_done.push_back(p_dev);
      end else if (((cyc - m_anchor) % DIV == 0) &&
                   !(cyc > m_acc && cyc < m_acc + FRAME_CYC)) begin
        p_ev.edge_n = cyc;
        p_ev.b      = m_lfsr[23];
        q_fill.push_back(p_ev);
        m_lfsr = lfsr_step(m_lfsr);
      end
    end
  end

  // Monitor: compare DUT outputs mid-cycle against the scoreboard.
  always @(negedge clk_in) begin
    if (reset !== 1'b1 || !m_live) begin
      prev_bit = 1'b0;
    end else begin
      check("ready", 32'(bus.ready), 32'(cyc >= m_ready_edge));
      check("in_frame", 32'(bus.in_frame), 32'(cyc >= m_acc && cyc < m_acc + FRAME_CYC));

      exp_strobe = (q_bits.size() > 0) && (q_bits[0].edge_n == cyc);
      exp_done   = (q_done.size() > 0) && (q_done[0].edge_n == cyc);
      exp_fill   = (q_fill.size() > 0) && (q_fill[0].edge_n == cyc);

      check("bit_strobe", 32'(bus.bit_strobe), 32'(exp_strobe));
      check("frame_done", 32'(bus.frame_done), 32'(exp_done));

      if (exp_strobe) begin
        mon_ev = q_bits.pop_front();
        check("pattern_bit", 32'(bus.bit_out), 32'(mon_ev.b));
      end else if (exp_fill) begin
        mon_ev = q_fill.pop_front();
        check("filler_bit", 32'(bus.bit_out), 32'(mon_ev.b));
      end else begin
        check("bit_hold", 32'(bus.bit_out), 32'(prev_bit));
      end

      if (exp_done) begin
        mon_dev = q_done.pop_front();
        check("sent_count", 32'(bus.sent_count), 32'(mon_dev.cnt));
      end
      prev_bit = bus.bit_out;
    end
  end

  task automatic wait_accept();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_in);
      if (m_acc == cyc) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic send_frame(input logic [PAT_W-1:0] p);
    @(negedge clk_in);
    bus.start   = 1'b1;
    bus.pattern = p;
    wait_accept();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_in);
      if (cyc >= m_ready_edge) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_timeout", 32'(ok), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"},      32'(bus.ready),      32'd1);
    check({tag, "_bit_out"},    32'(bus.bit_out),    32'd0);
    check({tag, "_bit_strobe"}, 32'(bus.bit_strobe), 32'd0);
    check({tag, "_in_frame"},   32'(bus.in_frame),   32'd0);
    check({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
    check({tag, "_sent_count"}, 32'(bus.sent_count), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start   = 1'b0;
    bus.pattern = '0;
    reset       = 1'b0;

    repeat (5) @(posedge clk_in);
    #1;
    check_reset_values("por");
    @(negedge clk_in);
    #1 reset = 1'b1;

    repeat (60) @(negedge clk_in);
    check("idle_ready", 32'(bus.ready), 32'd1);
    check("idle_count", 32'(bus.sent_count), 32'd0);

    // Single frame, with stray start pulses during SEND and GAP.
    send_frame(8'hB4);
    repeat (10) @(negedge clk_in);
    bus.start   = 1'b1;
    bus.pattern = 8'h3C;
    @(negedge clk_in);
    bus.start = 1'b0;
    repeat (40) @(negedge clk_in);
    bus.start   = 1'b1;
    bus.pattern = 8'h0F;
    @(negedge clk_in);
    bus.start = 1'b0;
    wait_idle();
    check("single_count", 32'(bus.sent_count), 32'd1);

    // start held high: three back-to-back frames.
    bus.pattern = 8'hB4;
    bus.start   = 1'b1;
    for (int f = 0; f < 3; f++) wait_accept();
    bus.start = 1'b0;
    wait_idle();
    check("held3_count", 32'(bus.sent_count), 32'd4);

    // Randomized patterns, accept phases and stray pulses.
    for (int f = 0; f < 20; f++) begin
      repeat ($urandom_range(0, 30)) @(negedge clk_in);
      send_frame(PAT_W'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 80)) @(negedge clk_in);
        bus.start   = 1'b1;
        bus.pattern = PAT_W'($urandom);
        @(negedge clk_in);
        bus.start = 1'b0;
      end
    end
    wait_idle();
    check("random_count", 32'(bus.sent_count), 32'd24);

    // Reset mid-frame: immediate reset values, no frame_done, LFSR reseeded.
    send_frame(8'hA5);
    repeat (13) @(posedge clk_in);
    #1 reset = 1'b0;
    #1;
    check_reset_values("abort");
    repeat (3) @(negedge clk_in);
    #1 reset = 1'b1;
    repeat (80) @(negedge clk_in);
    check("abort_count", 32'(bus.sent_count), 32'd0);

    // 256 frames wrap the counter; the first one is all ones.
    bus.pattern = 8'hFF;
    bus.start   = 1'b1;
    for (int f = 0; f < 256; f++) begin
      wait_accept();
      bus.pattern = PAT_W'($urandom);
    end
    bus.start = 1'b0;
    wait_idle();
    check("wrap_count", 32'(bus.sent_count), 32'd0);

    repeat (10) @(negedge clk_in);
    check("drain", 32'(q_bits.size() + q_done.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
